pio_edge_irq: RTL
=================

PIO_EDGE_IRQ -- requirements
Module: pio_edge_irq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, number of input channels (1..32).
REQ-002 SHALL have parameter: SYNC_STAGES, 2, input synchroniser depth (2..4).
REQ-003 SHALL have parameter: RISE_EN_RST, all-ones, reset value of rise-enable register.
REQ-004 SHALL have parameter: FALL_EN_RST, all-zeros, reset value of fall-enable register.
REQ-005 SHALL have port: clk  in  1  single clock; all logic in this one domain.
REQ-006 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: address  in  3  Avalon-MM word address.
REQ-008 SHALL have port: chipselect  in  1  slave select.
REQ-009 SHALL have port: write_n  in  1  active-low write strobe.
REQ-010 SHALL have port: writedata  in  32  write data.
REQ-011 SHALL have port: in_port  in  WIDTH  asynchronous external inputs.
REQ-012 SHALL have port: readdata  out  32  registered read data.
REQ-013 SHALL have port: irq  out  1  registered, level-sensitive interrupt request.

Function
REQ-014 SHALL use this register map (bits WIDTH-1:0; upper bits read 0): 0 DATA (RO, synchronised inputs); 1 RISE_EN (RW); 2 IRQ_MASK (RW); 3 CAPTURE (RW; a write of 1 clears the bit); 4 FALL_EN (RW); 5 SET (WO; a write of 1 sets the CAPTURE bit; reads 0); 6-7 reserved (reads 0; writes ignored).
REQ-015 SHALL perform a write when chipselect=1 and write_n=0; writes to DATA are ignored; RW registers update on the next clk edge.
REQ-016 SHALL register readdata every cycle from the current address, independent of chipselect, giving 1-cycle read latency.
REQ-017 SHALL pass each in_port bit through a SYNC_STAGES flop chain, followed by one further "previous" flop.
REQ-018 SHALL detect rise = sync & ~prev and fall = ~sync & prev, per bit.
REQ-019 SHALL form event = (rise & RISE_EN) | (fall & FALL_EN); a bit with both enables set captures either edge.
REQ-020 SHALL set a CAPTURE bit on the clk edge following its event; an in_port edge stable from cycle 0 sets CAPTURE at edge SYNC_STAGES+1.
REQ-021 SHALL make set dominate clear when an event or SET write coincides with a CAPTURE clear of the same bit: the bit ends set.
REQ-022 SHALL leave other bits unaffected by a clear or set; writedata bits at or above WIDTH are ignored.
REQ-023 SHALL compute irq <= |(CAPTURE & IRQ_MASK), one cycle after CAPTURE or IRQ_MASK changes.
REQ-024 SHALL keep CAPTURE set while its event persists; it never clears itself.
REQ-025 SHALL suppress event detection via an arm counter for SYNC_STAGES+1 cycles after reset deassertion, so inputs held high through reset create no capture.
REQ-026 SHALL abort all in-flight synchronisation and detection when reset is asserted mid-operation, then re-arm per REQ-025.

Reset
REQ-027 SHALL, while reset=1 at a clk edge, set: readdata=0, irq=0, IRQ_MASK=0, CAPTURE=0, sync chain and prev flops=0, RISE_EN=RISE_EN_RST, FALL_EN=FALL_EN_RST, arm counter=0 (disarmed).
REQ-028 SHALL ignore bus writes in any cycle where reset=1.

Structure
REQ-029 SHALL place address constants (ADDR_DATA..ADDR_SET) and the 3-bit address width in shared package pio_edge_irq_pkg.
REQ-030 SHALL implement the per-bit synchroniser, prev flop and rise/fall detect as sub-module pio_sync_edge, instantiated WIDTH times by generate.
REQ-031 SHALL keep the register file, arm counter, capture logic and read mux in the top level.

Verification (WIDTH=8, SYNC_STAGES=2, default enables)
REQ-032 SHALL cover: write IRQ_MASK=0x01, drive in_port 0x00->0x01 -> CAPTURE=0x01 at edge 3, irq=1 at edge 4; read addr 3 returns 0x00000001.
REQ-033 SHALL cover: write FALL_EN=0x02, RISE_EN=0x00, drive in_port bit1 1->0 -> CAPTURE=0x02; a rising edge on bit1 is not captured.
REQ-034 SHALL cover: with CAPTURE=0x03, write addr 3 data 0x01 -> CAPTURE=0x02; irq falls one cycle later if IRQ_MASK=0x01.
REQ-035 SHALL cover: a clear of bit0 in the same cycle bit0's event is detected -> CAPTURE bit0 remains 1.
REQ-036 SHALL cover: hold in_port=0xFF through reset, release -> CAPTURE stays 0x00 and DATA reads 0xFF after 3 cycles.
REQ-037 SHALL cover: write SET=0x80 with IRQ_MASK=0x80 -> CAPTURE=0x80 and irq=1 two edges after the write; a read of addr 5 returns 0.

Source files
------------

// File: rtl/pio_edge_irq_pkg.sv
// Shared constants and helpers for the PIO edge-capture interrupt block.
package pio_edge_irq_pkg;

    // Avalon-MM word address width and the register map.
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_SET      = 3'd5;

    // One strobe per writable register; at most one is high in a cycle.
    typedef struct packed {
        logic rise_en;
        logic irq_mask;
        logic capture_clr;
        logic fall_en;
        logic capture_set;
    } wr_sel_t;

    // Turn an accepted bus write into per-register strobes. DATA and the
    // reserved words decode to no strobe, so writes there are dropped.
    function automatic wr_sel_t decode_write(input logic [ADDR_W-1:0] addr,
                                             input logic              wr);
        wr_sel_t sel;
        sel = '0;
        if (wr) begin
            case (addr)
                ADDR_RISE_EN:  sel.rise_en     = 1'b1;
                ADDR_IRQ_MASK: sel.irq_mask    = 1'b1;
                ADDR_CAPTURE:  sel.capture_clr = 1'b1;
                ADDR_FALL_EN:  sel.fall_en     = 1'b1;
                ADDR_SET:      sel.capture_set = 1'b1;
                default:       sel             = '0;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// One input channel: metastability synchroniser, a "previous" flop and
// combinational rise/fall detection on the synchronised value.
module pio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    // chain_q[0] is the first flop after the pin, chain_q[SYNC_STAGES-1]
    // is the synchronised value seen by the rest of the design.
    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next state: shift the pin into the chain, remember the last sync value.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], din_i};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    // Synchroniser and previous-value flops; reset flushes anything in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM parallel input port with per-bit rise/fall edge capture and a
// masked, level-sensitive interrupt.
//
// Bus handshake: this slave has no wait states. A write is accepted in any
// cycle where chipselect=1 and write_n=0 and reset=0, and takes effect at
// that clock edge. readdata is registered every cycle from the address
// presented in the previous cycle, whether or not chipselect is asserted.
module pio_edge_irq
    import pio_edge_irq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RISE_EN_RST = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] FALL_EN_RST = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    // The arm counter runs from 0 up to SYNC_STAGES+1 and then holds. Edge
    // detection is only trusted once it has saturated, which hides the
    // spurious "rise" produced as a held-high input floods the freshly
    // reset synchroniser.
    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    // Per-channel synchroniser outputs.
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    // Register file.
    logic [WIDTH-1:0] rise_en_q,  rise_en_d;
    logic [WIDTH-1:0] fall_en_q,  fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] capture_q,  capture_d;

    // Arm counter and outputs.
    logic [ARM_W-1:0] arm_q, arm_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    // Decode and capture intermediates.
    wr_sel_t          wr_sel;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] event_bits;
    logic [WIDTH-1:0] rd_bits;
    logic             armed;

    // Bits of writedata above WIDTH have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // One synchroniser/edge detector per input channel.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk_i  (clk),
            .reset_i(reset),
            .din_i  (in_port[i]),
            .sync_o (sync_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    // Decode the bus write into register updates and capture clear/set masks.
    always_comb begin
        wr_sel     = decode_write(address, chipselect & ~write_n);
        wr_bits    = writedata[WIDTH-1:0];
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        clr_bits   = '0;
        set_bits   = '0;
        if (wr_sel.rise_en)     rise_en_d  = wr_bits;
        if (wr_sel.fall_en)     fall_en_d  = wr_bits;
        if (wr_sel.irq_mask)    irq_mask_d = wr_bits;
        if (wr_sel.capture_clr) clr_bits   = wr_bits;
        if (wr_sel.capture_set) set_bits   = wr_bits;
    end

    // Edge events gated by the enables and the arm counter; set wins over clear.
    always_comb begin
        armed      = (arm_q == ARM_DONE);
        arm_d      = armed ? arm_q : arm_q + ARM_W'(1);
        event_bits = '0;
        if (armed) begin
            event_bits = (rise_w & rise_en_q) | (fall_w & fall_en_q);
        end
        capture_d  = (capture_q & ~clr_bits) | set_bits | event_bits;
        irq_d      = |(capture_q & irq_mask_q);
    end

    // Read mux; SET and reserved words read as zero.
    always_comb begin
        rd_bits = '0;
        case (address)
            ADDR_DATA:     rd_bits = sync_w;
            ADDR_RISE_EN:  rd_bits = rise_en_q;
            ADDR_IRQ_MASK: rd_bits = irq_mask_q;
            ADDR_CAPTURE:  rd_bits = capture_q;
            ADDR_FALL_EN:  rd_bits = fall_en_q;
            default:       rd_bits = '0;
        endcase
        readdata_d = 32'(rd_bits);
    end

    // State update; reset also blocks any bus write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en_q  <= RISE_EN_RST;
            fall_en_q  <= FALL_EN_RST;
            irq_mask_q <= '0;
            capture_q  <= '0;
            arm_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            capture_q  <= capture_d;
            arm_q      <= arm_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
